// File: rtl/spi_cfg_pkg.sv
// spi_cfg_pkg: shared state type, divider helper and PLL-map frame field positions
package spi_cfg_pkg;

    typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SHIFT, S_TRAIL, S_GAP} spi_state_e;

    localparam int PLLF_READ      = 0;
    localparam int PLLF_WRITE     = 1;
    localparam int PLLF_PLLEN     = 2;
    localparam int PLLF_RATIO_LSB = 3;
    localparam int PLLF_RATIO_W   = 10;

    function automatic int spi_div(int clk_f, int sclk_f);
        return clk_f / (2 * sclk_f);
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: half-period counter, tick strobe and sclk toggle with idle level CPOL
module spi_sclk_gen #(
    parameter int DIV  = 5,
    parameter bit CPOL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic tick,
    output logic sclk
);
    localparam int CW = DIV > 1 ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = cnt == CW'(DIV - 1);

    // counter held at zero while idle so the first half-period starts cleanly
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else        cnt <= (clear || tick) ? '0 : cnt + 1'b1;

    // sclk toggles once per half-period while shifting, parked at CPOL otherwise
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)           sclk <= CPOL;
        else if (clear)       sclk <= CPOL;
        else if (run && tick) sclk <= ~sclk;

endmodule

// File: rtl/spi_master_cfg.sv
// spi_master_cfg: parametrised full-duplex SPI master with CPOL/CPHA, bit order and CS idle gap
module spi_master_cfg
    import spi_cfg_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int SCLK_FREQ  = 5_000_000,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  miso,
    output logic                  mosi,
    output logic                  sclk,
    output logic                  ss_n,
    output logic                  busy,
    output logic                  finish,
    output logic [DATA_WIDTH-1:0] data_o
);
    localparam int DIV  = spi_div(CLK_FREQ, SCLK_FREQ);
    localparam int BW   = $clog2(DATA_WIDTH + 1);
    // with CPHA=0 the last sample precedes the last trailing edge, so the count is already full
    localparam int LAST = CPHA ? DATA_WIDTH - 1 : DATA_WIDTH;

    if (DIV < 1 || CLK_FREQ % (2 * SCLK_FREQ) != 0 || DATA_WIDTH < 2) begin : g_bad_cfg
        $error("spi_master_cfg: CLK_FREQ/(2*SCLK_FREQ) must be an integer >= 1 and DATA_WIDTH >= 2");
    end

    spi_state_e            state, state_nx;
    logic                  tick, lead, trail, sample, shift, accept, mosi_q;
    logic [DATA_WIDTH-1:0] tx, rx, tx_adv, data_adv;
    logic [BW-1:0]         bit_cnt;

    spi_sclk_gen #(.DIV(DIV), .CPOL(CPOL)) u_sclk (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state == S_IDLE),
        .run   (state == S_SHIFT),
        .tick  (tick),
        .sclk  (sclk)
    );

    assign accept   = state == S_IDLE && start;
    assign lead     = state == S_SHIFT && tick && sclk == CPOL;
    assign trail    = state == S_SHIFT && tick && sclk != CPOL;
    assign sample   = CPHA ? trail : lead;
    assign shift    = CPHA ? lead : trail;
    assign tx_adv   = MSB_FIRST ? tx << 1 : tx >> 1;
    assign data_adv = MSB_FIRST ? data_i << 1 : data_i >> 1;
    assign mosi     = ss_n ? 1'b0 : mosi_q;

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;

    // next-state and chip-select/busy decode
    always_comb begin
        state_nx = state;
        ss_n     = !(state inside {S_LEAD, S_SHIFT, S_TRAIL});
        busy     = state != S_IDLE;
        case (state)
            S_IDLE:  if (start) state_nx = S_LEAD;
            S_LEAD:  if (tick) state_nx = S_SHIFT;
            S_SHIFT: if (trail && bit_cnt == BW'(LAST)) state_nx = S_TRAIL;
            S_TRAIL: if (tick) state_nx = S_GAP;
            S_GAP:   if (tick) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // transmit/receive shift registers and sample counter
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            tx      <= '0;
            rx      <= '0;
            bit_cnt <= '0;
            mosi_q  <= 1'b0;
        end else if (accept) begin
            tx      <= CPHA ? data_i : data_adv;
            mosi_q  <= CPHA ? 1'b0 : (MSB_FIRST ? data_i[DATA_WIDTH-1] : data_i[0]);
            bit_cnt <= '0;
        end else begin
            if (shift) begin
                mosi_q <= MSB_FIRST ? tx[DATA_WIDTH-1] : tx[0];
                tx     <= tx_adv;
            end
            if (sample) begin
                rx      <= MSB_FIRST ? {rx[DATA_WIDTH-2:0], miso} : {miso, rx[DATA_WIDTH-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
        end

    // frame completion pulse and received-data publish, coincident with ss_n release
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            finish <= 1'b0;
            data_o <= '0;
        end else begin
            finish <= state == S_TRAIL && tick;
            if (state == S_TRAIL && tick) data_o <= rx;
        end

endmodule

// File: tb/tb_spi_master_cfg.sv
// tb_spi_master_cfg: six master configurations, each with a slave model and a finish-driven scoreboard
module tb_spi_master_cfg;
    import spi_cfg_pkg::*;

    localparam int DIV = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [519:0] act, input logic [519:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    for (genvar g = 0; g < 6; g++) begin : u
        localparam int DW     = g == 5 ? 512 : 16;
        localparam bit CPOL_G = (g == 2) || (g == 3);
        localparam bit CPHA_G = (g == 1) || (g == 3);
        localparam bit MSB_G  = g == 4;

        logic          rst_n = 1'b0, start = 1'b0, miso = 1'b0;
        logic [DW-1:0] data_i = '0;
        logic          mosi, sclk, ss_n, busy, finish;
        logic [DW-1:0] data_o;

        logic [DW-1:0] exp_tx[$], exp_rx[$], resp_q[$];
        logic [DW-1:0] resp, c, cap;
        logic [1:0]    first2;
        int            kt, kr, nl, nlead, low = 0;
        bit            st, ld, stable, got = 0, fin = 0;
        logic          mosi_prev = 1'b0;

        spi_master_cfg #(
            .DATA_WIDTH (DW),
            .CLK_FREQ   (50_000_000),
            .SCLK_FREQ  (5_000_000),
            .CPOL       (CPOL_G),
            .CPHA       (CPHA_G),
            .MSB_FIRST  (MSB_G)
        ) dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .start  (start),
            .data_i (data_i),
            .miso   (miso),
            .mosi   (mosi),
            .sclk   (sclk),
            .ss_n   (ss_n),
            .busy   (busy),
            .finish (finish),
            .data_o (data_o)
        );

        function automatic int idx(input int k);
            return MSB_G ? DW - 1 - k : k;
        endfunction

        function automatic logic [DW-1:0] rnd();
            logic [DW-1:0] v;
            for (int i = 0; i < DW; i++) v[i] = 1'($urandom_range(1, 0));
            return v;
        endfunction

        task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] r, input bit expect_frame);
            int t = 0;
            while (busy !== 1'b0 && t < 20000) begin @(negedge clk); t++; end
            start = 1'b1;
            data_i = d;
            resp_q.push_back(r);
            if (expect_frame) begin exp_tx.push_back(d); exp_rx.push_back(r); end
            @(negedge clk);
            start = 1'b0;
            data_i = rnd();
        endtask

        task automatic wait_idle();
            int t = 0;
            while (busy !== 1'b0 && t < 20000) begin @(negedge clk); t++; end
            chk($sformatf("g%0d idle_reached", g), busy, 0);
        endtask

        always @(negedge clk) mosi_prev = mosi;

        // slave: drives the response on shift edges, captures mosi on sample edges
        always begin
            @(negedge ss_n);
            resp = resp_q.size() > 0 ? resp_q.pop_front() : '0;
            c = '0; kt = 0; kr = 0; nl = 0; st = 1'b1; got = 1'b0;
            if (!CPHA_G) miso = resp[idx(0)];
            while (ss_n == 1'b0) begin
                @(sclk or ss_n);
                if (ss_n) break;
                ld = sclk != CPOL_G;
                if (ld) nl++;
                if (ld != CPHA_G) begin
                    #1;
                    if (mosi !== mosi_prev) st = 1'b0;
                    if (kr < DW) c[idx(kr)] = mosi_prev;
                    if (kr < 2) first2[kr] = mosi_prev;
                    kr++;
                end else if (CPHA_G) begin
                    if (kt < DW) miso = resp[idx(kt)];
                    kt++;
                end else begin
                    kt++;
                    if (kt < DW) miso = resp[idx(kt)];
                end
            end
            if (kr == DW) begin cap = c; nlead = nl; stable = st; got = 1'b1; end
        end

        // monitor: every finish pulse is checked against the oldest pending frame
        always @(negedge clk) begin
            if (finish) begin
                chk($sformatf("g%0d exp_pending", g), exp_rx.size() > 0, 1);
                if (exp_rx.size() > 0) begin
                    chk($sformatf("g%0d data_o", g), data_o, exp_rx.pop_front());
                    chk($sformatf("g%0d mosi_frame", g), {got, cap}, {1'b1, exp_tx.pop_front()});
                    chk($sformatf("g%0d ss_n_low", g), low, (2 * DW + 2) * DIV);
                    chk($sformatf("g%0d ss_n_at_finish", g), ss_n, 1);
                    chk($sformatf("g%0d sclk_at_finish", g), sclk, CPOL_G);
                    chk($sformatf("g%0d lead_edges", g), nlead, DW);
                    chk($sformatf("g%0d mosi_stable", g), stable, 1);
                end
            end
            low = ss_n ? 0 : low + 1;
        end

        initial begin : stim
            logic [DW-1:0] d;
            int t, nacc, nfin, hi;
            logic pss;
            repeat (3) @(negedge clk);
            chk($sformatf("g%0d reset_outputs", g), {busy, ss_n, sclk, mosi, finish, |data_o},
                {1'b0, 1'b1, CPOL_G, 1'b0, 1'b0, 1'b0});
            rst_n = 1'b1;
            repeat (2) @(negedge clk);
            if (g == 0) begin
                send(16'hA55A, 16'hA55A, 1'b1);
                wait_idle();
            end
            if (g == 4) begin
                send(16'h8001, 16'h8001, 1'b1);
                wait_idle();
                chk("g4 first_two_bits", first2, 2'b01);
            end
            if (g == 5) begin
                d = '0;
                d[PLLF_WRITE] = 1'b1;
                d[PLLF_RATIO_LSB +: PLLF_RATIO_W] = 10'd11;
                send(d, rnd(), 1'b1);
                wait_idle();
                chk("g5 pll_decode", {cap[PLLF_READ], cap[PLLF_WRITE], cap[PLLF_PLLEN],
                    cap[PLLF_RATIO_LSB +: PLLF_RATIO_W]}, {3'b010, 10'd11});
            end
            if (g < 4) begin
                send(rnd(), 16'h3C0F, 1'b1);
                wait_idle();
            end
            if (g == 1) begin
                send(rnd(), rnd(), 1'b1);
                repeat (40) @(negedge clk);
                start = 1'b1;
                data_i = rnd();
                @(negedge clk);
                start = 1'b0;
                wait_idle();
                repeat (30) @(negedge clk);
                chk("g1 pulse_ignored", {ss_n, busy}, 2'b10);
                d = rnd();
                for (int i = 0; i < 3; i++) begin
                    exp_tx.push_back(d);
                    exp_rx.push_back(rnd());
                    resp_q.push_back(exp_rx[exp_rx.size() - 1]);
                end
                start = 1'b1;
                data_i = d;
                nacc = 0; nfin = 0; hi = 0; pss = 1'b1; t = 0;
                while (nfin < 3 && t < 3000) begin
                    @(negedge clk);
                    t++;
                    if (!ss_n && pss) begin
                        if (nacc > 0) chk("g1 b2b_gap", hi, DIV + 1);
                        nacc++;
                        if (nacc == 3) start = 1'b0;
                    end
                    hi = ss_n ? hi + 1 : 0;
                    pss = ss_n;
                    if (finish) nfin++;
                end
                start = 1'b0;
                chk("g1 b2b_finishes", nfin, 3);
                repeat (40) @(negedge clk);
                chk("g1 b2b_frames", {nacc, ss_n, busy}, {32'd3, 2'b10});
            end
            if (g == 2) begin
                send(rnd(), rnd(), 1'b0);
                t = 0;
                while (kr < 7 && t < 2000) begin @(negedge clk); t++; end
                #2 rst_n = 1'b0;
                #1 chk("g2 reset_async", {ss_n, sclk, busy, mosi}, {1'b1, CPOL_G, 2'b00});
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                repeat (5) @(negedge clk);
                chk("g2 data_o_after_abort", data_o, 0);
            end
            repeat (g == 5 ? 1 : 3) begin
                send(rnd(), rnd(), 1'b1);
                wait_idle();
            end
            repeat (20) @(negedge clk);
            chk($sformatf("g%0d idle_levels", g), {sclk, ss_n, busy}, {CPOL_G, 2'b10});
            chk($sformatf("g%0d queue_drained", g), exp_rx.size(), 0);
            fin = 1'b1;
        end
    end

    initial begin : top
        int t = 0;
        while (!(u[0].fin && u[1].fin && u[2].fin && u[3].fin && u[4].fin && u[5].fin) && t < 80000) begin
            @(negedge clk);
            t++;
        end
        chk("all_done", u[0].fin && u[1].fin && u[2].fin && u[3].fin && u[4].fin && u[5].fin, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_master_cfg.md
# spi_master_cfg

Parametrised SPI master, successor to the fixed 512-bit, mode-0 master that drives `pllmap_top` configuration frames. It adds:
- configurable frame width and clock ratio;
- all four CPOL/CPHA modes and selectable bit order;
- full-duplex MISO capture into `data_o`;
- a `busy` flag and a guaranteed chip-select idle gap.

It sits between the SoC/bench control logic and any SPI-slave register map, including the PLL map, on the system clock domain.

## Interface
Parameters:
- `DATA_WIDTH`, 512, frame length in bits (≥ 2).
- `CLK_FREQ`, 50_000_000, `clk` frequency in Hz.
- `SCLK_FREQ`, 5_000_000, target `sclk` frequency in Hz. `DIV = CLK_FREQ/(2*SCLK_FREQ)` must be an integer ≥ 1; elaboration fails otherwise.
- `CPOL`, 0, idle level of `sclk`.
- `CPHA`, 0:
  - 0: sample on the leading edge, shift on the trailing edge.
  - 1: shift on the leading edge, sample on the trailing edge.
- `MSB_FIRST`, 0. 0 sends `data_i[0]` first, which matches the existing PLL-map frame layout (read, write, pllen, ratio[9:0] at bits 0..12).

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: frame request, sampled on the rising edge of `clk`.
- `data_i` in `DATA_WIDTH`: transmit frame, latched the cycle `start` is accepted.
- `miso` in 1: serial input from the slave.
- `mosi` out 1: serial output to the slave.
- `sclk` out 1: serial clock.
- `ss_n` out 1: active-low slave select.
- `busy` out 1: high from start acceptance until the idle gap ends.
- `finish` out 1: one-cycle pulse at frame end.
- `data_o` out `DATA_WIDTH`: received frame, updated only with `finish`.

## Operation
- States:
  - IDLE → LEAD: `start` high and `busy` low; latch `data_i` into the shift register.
  - LEAD → SHIFT: after `DIV` cycles.
  - SHIFT → TRAIL: after `2*DATA_WIDTH` half-periods.
  - TRAIL → GAP: after `DIV` cycles.
  - GAP → IDLE: after `DIV` cycles.
- Half-period tick: a counter counts 0..`DIV`-1 and produces a tick at `DIV`-1. It is cleared on every state entry.
- SHIFT:
  - Each tick toggles `sclk`. Odd ticks are leading edges; even ticks are trailing edges.
  - Sample edge: MISO is shifted into the receive register.
  - Shift edge: the next TX bit is placed on `mosi`.
- CPHA=0: the first bit is on `mosi` from LEAD entry.
- CPHA=1: `mosi` is updated on the first leading edge.
- Bit counter: counts 0..`DATA_WIDTH`-1 and is incremented on each sample edge.
- Receive order mirrors transmit order: with `MSB_FIRST`=0, the first received bit lands in `data_o[0]`.
- `start` while `busy` is ignored (no queuing). `data_i` changes after acceptance have no effect.
- Reset values: `sclk`=`CPOL`, `ss_n`=1, `mosi`=0, `busy`=0, `finish`=0, `data_o`=0. State is IDLE.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronously). No `finish` is generated and `data_o` is not updated.
- `mosi` is driven 0 whenever `ss_n`=1.

## Timing
- Start acceptance at edge N:
  - At N+1: `ss_n` falls, `busy` rises, state is LEAD.
- First `sclk` edge at N+1+`DIV`.
- `ss_n` stays low for exactly `(2*DATA_WIDTH+2)*DIV` cycles.
- At TRAIL exit:
  - `ss_n` rises.
  - `finish` is high for that single cycle.
  - `data_o` is valid from the same cycle.
- `busy` falls `DIV` cycles after `ss_n` rises. The earliest next acceptance is that cycle, so the minimum `ss_n`-high gap is `DIV`+1 cycles.
- `sclk` duty cycle is exactly 50%, period `2*DIV` cycles. `sclk` returns to `CPOL` before `ss_n` rises.
- `start` held high continuously gives back-to-back frames, each separated by the minimum gap.

## Structure
- `spi_cfg_pkg` holds:
  - the state enum `spi_state_e`;
  - `function automatic int spi_div(int clk_f, int sclk_f)`;
  - PLL-frame field constants: `PLLF_READ`=0, `PLLF_WRITE`=1, `PLLF_PLLEN`=2, `PLLF_RATIO_LSB`=3, `PLLF_RATIO_W`=10.
- One sub-module, `spi_sclk_gen`, contains the half-period counter, tick generation and `sclk` toggle/idle-level logic. It is parameterised by `DIV` and `CPOL`.
- The FSM, shift registers and bit counter live in `spi_master_cfg`.

## Test plan
1. Mode 0, `DATA_WIDTH`=16, `DIV`=5, `MSB_FIRST`=0. Send `data_i`=16'hA55A with a MISO loopback from `mosi`.
   - `ss_n` low for 170 cycles, 16 rising `sclk` edges.
   - `data_o`=16'hA55A and `finish` are co-timed with the `ss_n` rise.
2. All four CPOL/CPHA modes, slave model returning 16'h3C0F. Each mode:
   - `data_o`=16'h3C0F;
   - `sclk` idle level equals `CPOL` outside frames;
   - `mosi` is stable across every sample edge.
3. `DATA_WIDTH`=512 defaults, PLL frame with write=1, ratio=11 (`data_i[12:0]`=13'h05A).
   - Slave decodes the frame as write, ratio 11.
   - Frame is 5130 cycles of `ss_n` low.
4. `start` pulsed at mid-frame, and `start` held high for 3 frames.
   - The mid-frame pulse is ignored.
   - Exactly 3 frames are sent, with a gap of 6 cycles.
5. `rst_n` asserted at bit 7 of a frame.
   - Same cycle: `ss_n`=1, `sclk`=`CPOL`, `busy`=0.
   - No `finish` pulse; `data_o` unchanged at 0.
   - The next `start` after reset sends a complete, correct frame.
6. `MSB_FIRST`=1, `data_i`=16'h8001, loopback.
   - The first `mosi` bit is 1 and the second is 0.
   - `data_o`=16'h8001.
